// File: rtl/frame_packer_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | shift_pkg : shared constants, count-width helper, queue occupancy states  |
// | Revision  : 1.0                                                            |
// +---------------------------------------------------------------------------+
package shift_pkg;

  localparam int QDEPTH = 2;

  function automatic int cnt_width(input int k);
    return $clog2(k + 1);
  endfunction

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } qstate_t;

endpackage
`default_nettype wire

// File: rtl/frame_packer_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | frame_packer_if : word input stream and frame output handshake bundle     |
// | Revision        : 1.0                                                      |
// +---------------------------------------------------------------------------+
interface frame_packer_if #(
  parameter int N = 4,
  parameter int K = 4
);

  logic                                InValid;
  logic [N-1:0]                        InData;
  logic                                InLast;
  logic                                OutValid;
  logic                                OutReady;
  logic [N*K-1:0]                      OutData;
  logic [shift_pkg::cnt_width(K)-1:0]  OutCount;
  logic                                Overflow;
  logic                                Busy;

  modport master (
    output InValid, InData, InLast, OutReady,
    input  OutValid, OutData, OutCount, Overflow, Busy
  );

  modport slave (
    input  InValid, InData, InLast, OutReady,
    output OutValid, OutData, OutCount, Overflow, Busy
  );

endinterface
`default_nettype wire

// File: rtl/frame_packer_queue.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | frame_queue : 2-entry frame FIFO with valid/ready head and full flag      |
// | Revision    : 1.0                                                          |
// +---------------------------------------------------------------------------+
module frame_queue
  import shift_pkg::*;
#(
  parameter int W     = 16,
  parameter int CW    = 3,
  parameter int DEPTH = QDEPTH
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic [CW-1:0] cnt_i,
  input  logic          ready_i,
  output logic          full_o,
  output logic          valid_o,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] head_cnt_o
);

  qstate_t       state_q, state_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [W-1:0]  data_q [DEPTH];
  logic [CW-1:0] cnt_q  [DEPTH];
  logic          pop;
  logic          push_ok;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= Q_EMPTY;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // A pop on the same edge frees a slot, so a push into FULL is still taken.
  always_comb begin
    pop     = ready_i && (state_q != Q_EMPTY);
    push_ok = push_i && ((state_q != Q_FULL) || pop);
    wr_d    = wr_q ^ push_ok;
    rd_d    = rd_q ^ pop;
    state_d = state_q;
    case (state_q)
      Q_EMPTY: if (push_ok) state_d = Q_ONE;
      Q_ONE: begin
        if (push_ok && !pop)      state_d = Q_FULL;
        else if (pop && !push_ok) state_d = Q_EMPTY;
      end
      Q_FULL:  if (pop && !push_ok) state_d = Q_ONE;
      default: state_d = Q_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else if (push_ok) begin
      data_q[wr_q] <= data_i;
      cnt_q[wr_q]  <= cnt_i;
    end
  end

  assign full_o     = (state_q == Q_FULL);
  assign valid_o    = (state_q != Q_EMPTY);
  assign head_o     = data_q[rd_q];
  assign head_cnt_o = cnt_q[rd_q];

endmodule
`default_nettype wire

// File: rtl/frame_packer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | frame_packer : packs N-bit words into K-word frames, queues them for sink |
// | Revision     : 1.0                                                         |
// +---------------------------------------------------------------------------+
module frame_packer
  import shift_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int QD = QDEPTH
) (
  input  logic           Clk,
  input  logic           Clr,
  frame_packer_if.slave  bus
);

  localparam int IW = $clog2(K);
  localparam int CW = cnt_width(K);
  localparam int FW = N * K;

  logic [FW-1:0] acc_q, acc_d;
  logic [FW-1:0] frame;
  logic [IW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;
  logic          close;
  logic          drop;
  logic          full;
  logic          head_valid;
  logic [CW-1:0] frame_cnt;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      acc_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      ovf_q <= ovf_d;
    end
  end

  // The closing word never lands in acc_q; it is merged straight into the pushed frame.
  always_comb begin
    frame = acc_q;
    for (int i = 0; i < K; i++) begin
      if (idx_q == IW'(i)) frame[i*N +: N] = bus.InData;
    end
    close     = bus.InValid && (bus.InLast || (idx_q == IW'(K - 1)));
    frame_cnt = CW'(idx_q) + CW'(1);
    acc_d     = acc_q;
    idx_d     = idx_q;
    if (bus.InValid) begin
      if (close) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = frame;
        idx_d = idx_q + IW'(1);
      end
    end
    drop  = close && full && !(bus.OutReady && head_valid);
    ovf_d = ovf_q | drop;
  end

  frame_queue #(
    .W     (FW),
    .CW    (CW),
    .DEPTH (QD)
  ) u_queue (
    .Clk        (Clk),
    .Clr        (Clr),
    .push_i     (close),
    .data_i     (frame),
    .cnt_i      (frame_cnt),
    .ready_i    (bus.OutReady),
    .full_o     (full),
    .valid_o    (head_valid),
    .head_o     (bus.OutData),
    .head_cnt_o (bus.OutCount)
  );

  assign bus.OutValid = head_valid;
  assign bus.Overflow = ovf_q;
  assign bus.Busy     = (idx_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_frame_packer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_frame_packer : directed + random stimulus, queue-based scoreboard      |
// | Revision        : 1.0                                                      |
// +---------------------------------------------------------------------------+
module tb_frame_packer;
  import shift_pkg::*;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int FW = N * K;
  localparam int CW = cnt_width(K);

  typedef struct {
    logic [FW-1:0] data;
    logic [CW-1:0] cnt;
  } frame_t;

  logic clk;
  logic clr;

  frame_packer_if #(.N(N), .K(K)) bus ();

  frame_packer #(.N(N), .K(K), .QD(2)) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mon_en  = 1'b0;
  frame_t     sb[$];
  logic [N-1:0] cur[$];
  int         occ   = 0;
  bit         m_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: words collect into a list; a frame forms at K words or on InLast.
  task automatic model_edge(input bit v, input logic [N-1:0] d, input bit l, input bit r);
    frame_t f;
    bit pop;
    pop = r && (occ > 0);
    if (v) begin
      cur.push_back(d);
      if (cur.size() == K || l) begin
        f.data = '0;
        foreach (cur[i]) f.data |= FW'(cur[i]) << (i * N);
        f.cnt = CW'(cur.size());
        cur.delete();
        if (occ < 2 || pop) begin
          sb.push_back(f);
          occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (pop) occ--;
  endtask

  task automatic cyc(input bit v, input logic [N-1:0] d, input bit l, input bit r);
    bus.InValid  = v;
    bus.InData   = d;
    bus.InLast   = l;
    bus.OutReady = r;
    @(posedge clk);
    model_edge(v, d, l, r);
    #1;
  endtask

  task automatic do_reset();
    #1 clr = 1'b1;
    #1;
    chk("rst_OutValid", {63'd0, bus.OutValid}, 64'd0);
    chk("rst_Busy",     {63'd0, bus.Busy},     64'd0);
    chk("rst_Overflow", {63'd0, bus.Overflow}, 64'd0);
    chk("rst_OutData",  64'(bus.OutData),      64'd0);
    chk("rst_OutCount", 64'(bus.OutCount),     64'd0);
    clr = 1'b0;
    cur.delete();
    sb.delete();
    occ   = 0;
    m_ovf = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("OutValid", {63'd0, bus.OutValid}, {63'd0, sb.size() > 0});
      chk("Busy",     {63'd0, bus.Busy},     {63'd0, cur.size() != 0});
      chk("Overflow", {63'd0, bus.Overflow}, {63'd0, m_ovf});
      chk("qstate",   64'(dut.u_queue.state_q), 64'(qstate_t'(sb.size())));
      if (sb.size() > 0) begin
        chk("OutData",  64'(bus.OutData),  64'(sb[0].data));
        chk("OutCount", 64'(bus.OutCount), 64'(sb[0].cnt));
        if (bus.OutReady) void'(sb.pop_front());
      end
    end
  end

  initial begin
    clr          = 1'b1;
    bus.InValid  = 1'b0;
    bus.InData   = '0;
    bus.InLast   = 1'b0;
    bus.OutReady = 1'b0;
    #1;
    chk("init_OutValid", {63'd0, bus.OutValid}, 64'd0);
    chk("init_OutData",  64'(bus.OutData),      64'd0);
    chk("init_Busy",     {63'd0, bus.Busy},     64'd0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    mon_en = 1'b1;

    // Full frame 1,2,3,4 then early close A,B
    for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);
    cyc(1'b1, 4'hA, 1'b0, 1'b1);
    cyc(1'b1, 4'hB, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Push and pop together while full
    do_reset();
    for (int i = 1; i <= 11; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
    cyc(1'b1, 4'hC, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Backpressure with overflow, then drain
    do_reset();
    for (int i = 1; i <= 12; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Reset mid-frame, then a clean frame
    do_reset();
    cyc(1'b1, 4'h7, 1'b0, 1'b1);
    cyc(1'b1, 4'h8, 1'b0, 1'b1);
    do_reset();
    for (int i = 5; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Idle gaps between words
    for (int i = 0; i < 8; i++) cyc(i % 2 == 0, 4'(i + 3), 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) == 1);
    end

    repeat (4) cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("drained", 64'(sb.size()), 64'd0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
